// File: rtl/fp_add_iter.sv
// Iterative floating-point adder/subtractor. Alignment and the add take one cycle each,
// normalisation shifts left one bit per cycle, then rounding; specials bypass to DONE.
module fp_add_iter #(
  parameter int unsigned EW = 5,
  parameter int unsigned MW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+MW:0]    x,
  input  logic [EW+MW:0]    z,
  input  logic              sub,
  input  logic              rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW:0]    sum,
  output logic [2:0]        flags
);

  localparam int unsigned FW = 1 + EW + MW;
  localparam int unsigned SW = MW + 4;  // {hidden, frac, G, R, S}
  localparam int unsigned XW = EW + 1;  // exponent with headroom for carry/round-up

  localparam logic [FW-1:0] QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [XW-1:0] EXP_OVF = {1'b0, {EW{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [FW-1:0] sum_q, sum_d;
  logic [2:0]    flags_q, flags_d;
  logic [FW-1:0] x_q, x_d;
  logic [FW-1:0] z_q, z_d;      // z with its effective sign already applied
  logic          rm_q, rm_d;
  logic          sign_q, sign_d;
  logic          esub_q, esub_d;
  logic [XW-1:0] exp_q, exp_d;
  logic [SW-1:0] big_q, big_d;
  logic [SW-1:0] small_q, small_d;
  logic [SW:0]   acc_q, acc_d;  // extra top bit catches the addition carry

  // Operand classification on the input bus
  logic          z_sgn;
  logic          x_nan, z_nan, x_inf, z_inf, x_zero, z_zero;
  logic          fast_hit;
  logic [FW-1:0] fast_sum;
  logic [2:0]    fast_flg;

  assign z_sgn  = z[FW-1] ^ sub;
  assign x_nan  = (&x[FW-2:MW]) & (|x[MW-1:0]);
  assign z_nan  = (&z[FW-2:MW]) & (|z[MW-1:0]);
  assign x_inf  = (&x[FW-2:MW]) & ~(|x[MW-1:0]);
  assign z_inf  = (&z[FW-2:MW]) & ~(|z[MW-1:0]);
  assign x_zero = ~(|x[FW-2:MW]);
  assign z_zero = ~(|z[FW-2:MW]);

  always_comb begin
    fast_sum = '0;
    fast_flg = '0;
    fast_hit = 1'b1;
    if (x_nan || z_nan) begin
      fast_sum = QNAN;
    end else if (x_inf && z_inf && (x[FW-1] != z_sgn)) begin
      fast_sum = QNAN;
      fast_flg = 3'b100;
    end else if (x_inf) begin
      fast_sum = x;
    end else if (z_inf) begin
      fast_sum = {z_sgn, z[FW-2:0]};
    end else if (x_zero && z_zero) begin
      fast_sum = {x[FW-1] & z_sgn, {(FW-1){1'b0}}};
    end else if (x_zero) begin
      fast_sum = {z_sgn, z[FW-2:0]};
    end else if (z_zero) begin
      fast_sum = x;
    end else begin
      fast_hit = 1'b0;
    end
  end

  // Alignment: pick the larger magnitude, shift the other right with sticky collection
  logic          x_big;
  logic [EW-1:0] e_big, e_sml, e_dif;
  logic [SW-1:0] m_big, m_sml, m_shf;
  logic          sticky;

  assign x_big = x_q[FW-2:0] >= z_q[FW-2:0];

  always_comb begin
    e_big  = x_big ? x_q[FW-2:MW] : z_q[FW-2:MW];
    e_sml  = x_big ? z_q[FW-2:MW] : x_q[FW-2:MW];
    m_big  = {1'b1, (x_big ? x_q[MW-1:0] : z_q[MW-1:0]), 3'b000};
    m_sml  = {1'b1, (x_big ? z_q[MW-1:0] : x_q[MW-1:0]), 3'b000};
    e_dif  = e_big - e_sml;
    sticky = 1'b0;
    if (32'(e_dif) >= SW) begin
      m_shf = SW'(1);
    end else begin
      m_shf    = m_sml >> e_dif;
      sticky   = |(m_sml & ~({SW{1'b1}} << e_dif));
      m_shf[0] = m_shf[0] | sticky;
    end
  end

  // Rounding of the normalised significand; a carry out renormalises immediately
  logic          rnd_inc;
  logic [MW+1:0] mant;
  logic [XW-1:0] fexp;
  logic [MW-1:0] ffrc;

  always_comb begin
    rnd_inc = ~rm_q & acc_q[2] & (acc_q[1] | acc_q[0] | acc_q[3]);
    mant    = {1'b0, acc_q[SW-1:3]} + (MW+2)'(rnd_inc);
    fexp    = exp_q;
    ffrc    = mant[MW-1:0];
    if (mant[MW+1]) begin
      fexp = exp_q + XW'(1);
      ffrc = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    x_d     = x_q;
    z_d     = z_q;
    rm_d    = rm_q;
    sign_d  = sign_q;
    esub_d  = esub_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d  = x;
          z_d  = {z_sgn, z[FW-2:0]};
          rm_d = rm;
          if (fast_hit) begin
            sum_d   = fast_sum;
            flags_d = fast_flg;
            state_d = S_DONE;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        sign_d  = x_big ? x_q[FW-1] : z_q[FW-1];
        esub_d  = x_q[FW-1] ^ z_q[FW-1];
        exp_d   = {1'b0, e_big};
        big_d   = m_big;
        small_d = m_shf;
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d   = esub_q ? ({1'b0, big_q} - {1'b0, small_q})
                         : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (~(|acc_q)) begin
          sum_d   = '0;
          flags_d = '0;
          state_d = S_DONE;
        end else if (acc_q[SW]) begin
          acc_d   = {1'b0, acc_q[SW:2], acc_q[1] | acc_q[0]};
          exp_d   = exp_q + XW'(1);
          state_d = S_ROUND;
        end else if (acc_q[SW-1]) begin
          state_d = S_ROUND;
        end else if (exp_q == XW'(1)) begin
          sum_d   = '0;
          flags_d = 3'b001;
          state_d = S_DONE;
        end else begin
          acc_d = {acc_q[SW-1:0], 1'b0};
          exp_d = exp_q - XW'(1);
        end
      end
      S_ROUND: begin
        if (fexp >= EXP_OVF) begin
          sum_d   = rm_q ? {sign_q, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}}
                         : {sign_q, {EW{1'b1}}, {MW{1'b0}}};
          flags_d = 3'b010;
        end else begin
          sum_d   = {sign_q, fexp[EW-1:0], ffrc};
          flags_d = '0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_d  = (state_d == S_IDLE);
  assign out_valid_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
      x_q         <= '0;
      z_q         <= '0;
      rm_q        <= 1'b0;
      sign_q      <= 1'b0;
      esub_q      <= 1'b0;
      exp_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      x_q         <= x_d;
      z_q         <= z_d;
      rm_q        <= rm_d;
      sign_q      <= sign_d;
      esub_q      <= esub_d;
      exp_q       <= exp_d;
      big_q       <= big_d;
      small_q     <= small_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_add_iter.sv
// Directed and randomised bench for fp_add_iter (half precision) against an exact
// integer-arithmetic reference model.
module tb_fp_add_iter;

  localparam int unsigned EW = 5;
  localparam int unsigned MW = 10;
  localparam int unsigned FW = 1 + EW + MW;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [FW-1:0] x         = '0;
  logic [FW-1:0] z         = '0;
  logic          sub       = 1'b0;
  logic          rm        = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FW-1:0] sum;
  logic [2:0]    flags;

  int n_chk  = 0;
  int n_fail = 0;

  fp_add_iter #(.EW(EW), .MW(MW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .z         (z),
    .sub       (sub),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact reference: operands become signed integers in units of 2^-24, then the
  // true sum is normalised and rounded; rl = -1 means latency is not predicted.
  function automatic void model(input logic [15:0] xi, input logic [15:0] zi,
                                input logic si, input logic ri,
                                output logic [15:0] rs, output logic [2:0] rf, output int rl);
    logic   xs, zs, xnan, znan, xinf, zinf, xzer, zzer;
    int     xe, ze, p, en, ef, sh, eb;
    longint a, b, s, mag, keep, rem, half, one;
    one  = 1;
    xs   = xi[15];
    zs   = zi[15] ^ si;
    xe   = int'(xi[14:10]);
    ze   = int'(zi[14:10]);
    xnan = (xe == 31) && (xi[9:0] != 10'h0);
    znan = (ze == 31) && (zi[9:0] != 10'h0);
    xinf = (xe == 31) && (xi[9:0] == 10'h0);
    zinf = (ze == 31) && (zi[9:0] == 10'h0);
    xzer = (xe == 0);
    zzer = (ze == 0);
    rs = 16'h0000;
    rf = 3'b000;
    rl = 1;
    if (xnan || znan) rs = 16'h7E00;
    else if (xinf && zinf && (xs != zs)) begin
      rs = 16'h7E00;
      rf = 3'b100;
    end
    else if (xinf) rs = xi;
    else if (zinf) rs = {zs, zi[14:0]};
    else if (xzer && zzer) rs = {xs & zs, 15'h0000};
    else if (xzer) rs = {zs, zi[14:0]};
    else if (zzer) rs = xi;
    else begin
      rl = -1;
      a  = longint'(1024 + int'(xi[9:0]));
      a  = a << (xe - 1);
      b  = longint'(1024 + int'(zi[9:0]));
      b  = b << (ze - 1);
      if (xs) a = -a;
      if (zs) b = -b;
      s = a + b;
      if (s != 0) begin
        mag = (s < 0) ? -s : s;
        p = 0;
        for (int i = 0; i < 62; i++) if (mag[i]) p = i;
        en = p - 9;
        if (en < 1) rf = 3'b001;
        else begin
          sh = p - 10;
          if (sh > 0) begin
            keep = mag >> sh;
            rem  = mag - (keep << sh);
            half = one << (sh - 1);
            if (!ri && ((rem > half) || ((rem == half) && keep[0]))) keep = keep + 1;
          end else keep = mag << (-sh);
          ef = en;
          if (keep == 2048) begin
            keep = 1024;
            ef   = ef + 1;
          end
          eb = (xe > ze) ? xe : ze;
          rl = 5 + ((eb > en) ? (eb - en) : 0);
          if (ef >= 31) begin
            rf = 3'b010;
            rs = {s < 0, (ri ? 15'h7BFF : 15'h7C00)};
          end else rs = {s < 0, 5'(ef), 10'(keep)};
        end
      end
    end
  endfunction

  task automatic do_op(input string tag, input logic [15:0] xi, input logic [15:0] zi,
                       input logic si, input logic ri, input int hold,
                       input logic [15:0] es, input logic [2:0] ef, input int el);
    int lat;
    chk({tag, " ready"}, 32'(in_ready), 32'd1);
    x = xi; z = zi; sub = si; rm = ri; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " flags"}, 32'(flags), 32'(ef));
    if (el >= 0) chk({tag, " latency"}, 32'(lat), 32'(el));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold"}, {11'h0, out_valid, in_ready, flags, sum}, {11'h0, 1'b1, 1'b0, ef, es});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " release"}, {30'h0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, es;
    logic [2:0]  ef;
    int          el, e;

    #1 reset_n = 1'b0;
    #1 chk("reset outputs", {11'h0, out_valid, in_ready, flags, sum}, {11'h0, 1'b0, 1'b1, 3'b000, 16'h0000});
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    do_op("one+one hold", 16'h3C00, 16'h3C00, 1'b0, 1'b0, 10, 16'h4000, 3'b000, 5);
    do_op("one-near",     16'h3C00, 16'h3BFF, 1'b1, 1'b0, 0,  16'h1000, 3'b000, 16);
    do_op("cancel",       16'h3C00, 16'h3C00, 1'b1, 1'b0, 0,  16'h0000, 3'b000, -1);
    do_op("ovf rne",      16'h7BFF, 16'h7BFF, 1'b0, 1'b0, 0,  16'h7C00, 3'b010, 5);
    do_op("ovf rtz",      16'h7BFF, 16'h7BFF, 1'b0, 1'b1, 0,  16'h7BFF, 3'b010, 5);
    do_op("inf-inf",      16'h7C00, 16'h7C00, 1'b1, 1'b0, 0,  16'h7E00, 3'b100, 1);
    do_op("x+zero",       16'h3E00, 16'h0000, 1'b0, 1'b0, 0,  16'h3E00, 3'b000, 1);
    do_op("zero-x",       16'h0000, 16'h3C00, 1'b1, 1'b0, 0,  16'hBC00, 3'b000, 1);
    do_op("nz+nz",        16'h8000, 16'h8000, 1'b0, 1'b0, 0,  16'h8000, 3'b000, 1);
    do_op("nz-pz",        16'h8000, 16'h0000, 1'b1, 1'b0, 0,  16'h8000, 3'b000, 1);
    do_op("pz+nz",        16'h0000, 16'h8000, 1'b0, 1'b0, 0,  16'h0000, 3'b000, 1);
    do_op("nan",          16'h7D00, 16'h3C00, 1'b0, 1'b0, 0,  16'h7E00, 3'b000, 1);
    do_op("ninf+x",       16'hFC00, 16'h3C00, 1'b0, 1'b0, 0,  16'hFC00, 3'b000, 1);
    do_op("underflow",    16'h0500, 16'h0400, 1'b1, 1'b0, 0,  16'h0000, 3'b001, -1);
    do_op("tie even",     16'h6400, 16'h3800, 1'b0, 1'b0, 0,  16'h6400, 3'b000, 5);
    do_op("tie up",       16'h6401, 16'h3800, 1'b0, 1'b0, 0,  16'h6402, 3'b000, 5);
    do_op("tie rtz",      16'h6401, 16'h3800, 1'b0, 1'b1, 0,  16'h6401, 3'b000, 5);

    // Abort an operation mid-normalisation with an asynchronous reset
    x = 16'h3C00; z = 16'h3BFF; sub = 1'b1; rm = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("abort async", {30'h0, out_valid, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 chk("abort held", {11'h0, out_valid, in_ready, flags, sum}, {11'h0, 1'b0, 1'b1, 3'b000, 16'h0000});
    reset_n = 1'b1;
    do_op("after abort",  16'h3E00, 16'h3C00, 1'b0, 1'b0, 0,  16'h4100, 3'b000, 5);

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 2 == 0) begin
        e = int'(ra[14:10]) + int'($urandom_range(0, 4)) - 2;
        if (e < 1) e = 1;
        if (e > 30) e = 30;
        rb[14:10] = 5'(e);
      end
      if (i % 4 == 0) rb[9:0] = ra[9:0] ^ 10'($urandom_range(0, 7));
      if (i % 8 == 1) begin
        ra[14:10] = 5'($urandom_range(1, 2));
        rb[14:10] = 5'($urandom_range(1, 2));
        rb[15]    = ra[15];
      end
      model(ra, rb, i[0], i[1], es, ef, el);
      do_op($sformatf("rand%0d", i), ra, rb, i[0], i[1], 0, es, ef, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
